alu_op_issue: RTL and testbench
===============================

// Module: alu_op_issue
// PURPOSE
//  Producer side of the ALU Operation interface. Decodes ALUOp/Funct3/Funct7 from the
//  decode stage into the 4-bit ALU Operation code and registers it into the execute
//  stage. Uses a valid/ready handshake with a 2-entry skid buffer, so backpressure
//  never drops or duplicates an op. Flags illegal encodings and counts them.
// PARAMETERS
//  OPCODE_LENGTH  4  width of Operation (ALU opcode)
//  ALUOP_WIDTH    2  width of ALUOp from main control
//  CNT_WIDTH      8  width of saturating illegal-op counter
// PORTS
//  clk           in   1              clock, all state on rising edge
//  reset         in   1              synchronous, active-low
//  flush         in   1              sync pipeline flush (branch taken / trap)
//  in_valid      in   1              decode stage presents an op
//  in_ready      out  1              block can accept an op this cycle
//  ALUOp         in   ALUOP_WIDTH    00 ld/st, 01 branch, 10 R-type, 11 I-type ALU
//  Funct3        in   3              instruction funct3
//  Funct7        in   7              instruction funct7
//  out_valid     out  1              Operation/Illegal valid toward execute stage
//  out_ready     in   1              execute stage consumes when out_valid&&out_ready
//  Operation     out  OPCODE_LENGTH  ALU opcode
//  Illegal       out  1              op had no legal encoding (Operation=4'b1111)
//  IllegalCount  out  CNT_WIDTH      saturating count of illegal ops accepted
// BEHAVIOUR
//  Decode (combinational, on input fields):
//   ALUOp=00 -> 0010 ADD.  ALUOp=01: f3=000 -> 1000 EQUAL, else 0011 SUB.
//   ALUOp=10: f3=000,f7=0000000 ADD 0010; f3=000,f7=0100000 SUB 0011;
//             f3=111 AND 0000; f3=110 OR 0001; f3=100 XOR 0100; f3=001,f7=0 SLL 0110.
//             For AND/OR/XOR, f7 must be 0000000.
//   ALUOp=11: f3=000 0010; 111 0000; 110 0001; 100 0100; 001 with f7=0 -> 0110.
//   Any other combination -> Operation=1111, Illegal=1.
//  Storage: main reg (drives outputs) + skid reg. in_ready = !skid_valid (0 while reset low).
//  Accept = in_valid && in_ready; consume = out_valid && out_ready.
//  Latency: accepted op appears on outputs the next cycle when main is empty or consumed.
//   Otherwise it parks in skid and moves to main on the cycle after main is consumed.
//  Order is strictly FIFO. Simultaneous accept+consume with skid empty: main reloads and
//   out_valid stays 1.
//  Full: main+skid valid -> in_ready=0 and in_valid is ignored.
//  Outputs are stable while out_valid && !out_ready.
//  flush=1: main and skid invalidated next cycle (out_valid=0). Any op presented that
//   cycle is discarded and not counted. flush has priority over accept/consume.
//  IllegalCount += 1 per accepted illegal op (not flushed). Saturates at all-ones.
//  Reset (reset=0 at edge): out_valid=0, Operation=0000, Illegal=0, IllegalCount=0,
//   skid cleared. Mid-stream reset drops all in-flight ops; in_ready=1 the first cycle
//   after reset returns high.
// TESTING
//  1 ALUOp=10,f3=000,f7=0100000,in_valid=1,out_ready=1 -> next cycle out_valid=1,Op=0011.
//  2 ALUOp=01,f3=000 -> Op=1000; then f3=001 -> Op=0011; back-to-back, one per cycle.
//  3 out_ready=0, send ADD,XOR,AND -> in_ready=0 after 2nd; Op holds 0010; release ->
//    0010 then 0100, 3rd accepted; no loss or duplicate.
//  4 ALUOp=10,f3=010 -> Illegal=1,Op=1111,IllegalCount=1; 300 illegal ops -> count=255.
//  5 Skid full, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1,
//    count unchanged.
//  6 Skid full, reset=0 for 1 cycle -> all outputs at reset values; new op issues normally.

Source files
------------

// File: rtl/alu_op_issue.sv
// ALU operation issue: decodes ALUOp/Funct3/Funct7 into an ALU opcode and hands it to
// execute over valid/ready, with a one-entry skid register behind the output register.
module alu_op_issue #(
   parameter int OPCODE_LENGTH = 4,
   parameter int ALUOP_WIDTH   = 2,
   parameter int CNT_WIDTH     = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [ALUOP_WIDTH-1:0]   ALUOp,
   input  logic [2:0]               Funct3,
   input  logic [6:0]               Funct7,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [OPCODE_LENGTH-1:0] Operation,
   output logic                     Illegal,
   output logic [CNT_WIDTH-1:0]     IllegalCount
);

   localparam logic [OPCODE_LENGTH-1:0] OP_AND   = OPCODE_LENGTH'(4'b0000);
   localparam logic [OPCODE_LENGTH-1:0] OP_OR    = OPCODE_LENGTH'(4'b0001);
   localparam logic [OPCODE_LENGTH-1:0] OP_ADD   = OPCODE_LENGTH'(4'b0010);
   localparam logic [OPCODE_LENGTH-1:0] OP_SUB   = OPCODE_LENGTH'(4'b0011);
   localparam logic [OPCODE_LENGTH-1:0] OP_XOR   = OPCODE_LENGTH'(4'b0100);
   localparam logic [OPCODE_LENGTH-1:0] OP_SLL   = OPCODE_LENGTH'(4'b0110);
   localparam logic [OPCODE_LENGTH-1:0] OP_EQUAL = OPCODE_LENGTH'(4'b1000);
   localparam logic [OPCODE_LENGTH-1:0] OP_ILL   = '1;
   localparam logic [6:0]               F7_ZERO  = 7'b0000000;
   localparam logic [6:0]               F7_ALT   = 7'b0100000;

   logic [OPCODE_LENGTH-1:0] op_p0;
   logic                     ill_p0;

   // Output (main) register and the skid register parked behind it
   logic [OPCODE_LENGTH-1:0] op_p1, op_sk;
   logic                     ill_p1, ill_sk;
   logic                     vld_p1, vld_sk;
   logic [CNT_WIDTH-1:0]     cnt;

   logic accept, consume;

   // Stage 0: combinational decode of the instruction fields
   always_comb begin
      op_p0  = OP_ILL;
      ill_p0 = 1'b1;
      if (ALUOp == ALUOP_WIDTH'(0)) begin
         op_p0  = OP_ADD;
         ill_p0 = 1'b0;
      end else if (ALUOp == ALUOP_WIDTH'(1)) begin
         op_p0  = (Funct3 == 3'b000) ? OP_EQUAL : OP_SUB;
         ill_p0 = 1'b0;
      end else if (ALUOp == ALUOP_WIDTH'(2)) begin
         case (Funct3)
            3'b000: begin
               if (Funct7 == F7_ZERO) begin
                  op_p0 = OP_ADD; ill_p0 = 1'b0;
               end else if (Funct7 == F7_ALT) begin
                  op_p0 = OP_SUB; ill_p0 = 1'b0;
               end
            end
            3'b111: if (Funct7 == F7_ZERO) begin op_p0 = OP_AND; ill_p0 = 1'b0; end
            3'b110: if (Funct7 == F7_ZERO) begin op_p0 = OP_OR;  ill_p0 = 1'b0; end
            3'b100: if (Funct7 == F7_ZERO) begin op_p0 = OP_XOR; ill_p0 = 1'b0; end
            3'b001: if (Funct7 == F7_ZERO) begin op_p0 = OP_SLL; ill_p0 = 1'b0; end
            default: ;
         endcase
      end else if (ALUOp == ALUOP_WIDTH'(3)) begin
         // Immediate forms ignore Funct7 except for the shift, where it is part of the encoding
         case (Funct3)
            3'b000: begin op_p0 = OP_ADD; ill_p0 = 1'b0; end
            3'b111: begin op_p0 = OP_AND; ill_p0 = 1'b0; end
            3'b110: begin op_p0 = OP_OR;  ill_p0 = 1'b0; end
            3'b100: begin op_p0 = OP_XOR; ill_p0 = 1'b0; end
            3'b001: if (Funct7 == F7_ZERO) begin op_p0 = OP_SLL; ill_p0 = 1'b0; end
            default: ;
         endcase
      end
   end

   assign in_ready = reset && !vld_sk;
   assign accept   = in_valid && in_ready;
   assign consume  = vld_p1 && out_ready;

   // Stage 1: main/skid registers; flush outranks both accept and consume
   always_ff @(posedge clk) begin
      if (!reset) begin
         vld_p1 <= 1'b0;
         op_p1  <= '0;
         ill_p1 <= 1'b0;
         vld_sk <= 1'b0;
         op_sk  <= '0;
         ill_sk <= 1'b0;
         cnt    <= '0;
      end else if (flush) begin
         vld_p1 <= 1'b0;
         vld_sk <= 1'b0;
      end else begin
         if (!vld_p1 || consume) begin
            if (vld_sk) begin
               op_p1  <= op_sk;
               ill_p1 <= ill_sk;
               vld_p1 <= 1'b1;
               vld_sk <= 1'b0;
            end else if (accept) begin
               op_p1  <= op_p0;
               ill_p1 <= ill_p0;
               vld_p1 <= 1'b1;
            end else begin
               vld_p1 <= 1'b0;
            end
         end else if (accept) begin
            op_sk  <= op_p0;
            ill_sk <= ill_p0;
            vld_sk <= 1'b1;
         end
         if (accept && ill_p0 && (cnt != '1))
            cnt <= cnt + 1'b1;
      end
   end

   assign out_valid    = vld_p1;
   assign Operation    = op_p1;
   assign Illegal      = ill_p1;
   assign IllegalCount = cnt;

endmodule

// File: tb/tb_alu_op_issue.sv
// Bench for alu_op_issue: table of decode vectors plus directed backpressure, flush and
// reset sequences, all checked through an in-order scoreboard of expected ops.
module tb_alu_op_issue;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       flush = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [1:0] ALUOp = 2'b00;
   logic [2:0] Funct3 = 3'b000;
   logic [6:0] Funct7 = 7'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [3:0] Operation;
   logic       Illegal;
   logic [7:0] IllegalCount;

   alu_op_issue #(.OPCODE_LENGTH(4), .ALUOP_WIDTH(2), .CNT_WIDTH(8)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .ALUOp(ALUOp), .Funct3(Funct3), .Funct7(Funct7),
      .out_valid(out_valid), .out_ready(out_ready),
      .Operation(Operation), .Illegal(Illegal), .IllegalCount(IllegalCount)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] aluop;
      logic [2:0] f3;
      logic [6:0] f7;
      logic [3:0] op;
      logic       ill;
   } vec_t;

   typedef struct {
      logic [3:0] op;
      logic       ill;
   } exp_t;

   exp_t       q[$];
   logic [3:0] cur_op = 4'h0;
   logic       cur_ill = 1'b0;
   int         exp_cnt = 0;
   int         errors = 0;
   int         checks = 0;
   vec_t       vecs[19];

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
      end
   endfunction

   // Scoreboard monitor, sampling on the falling edge while inputs are stable
   always @(negedge clk) begin
      chk("illegal_count", 32'(IllegalCount), 32'(exp_cnt));
      if (!reset) begin
         chk("in_ready_in_reset", 32'(in_ready), 32'd0);
         q.delete();
         exp_cnt = 0;
      end else begin
         chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
         chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
         if (q.size() != 0) begin
            chk("operation", 32'(Operation), 32'(q[0].op));
            chk("illegal", 32'(Illegal), 32'(q[0].ill));
         end
         if (flush) begin
            q.delete();
         end else begin
            if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
            if (in_valid && in_ready) begin
               q.push_back('{op: cur_op, ill: cur_ill});
               if (cur_ill && exp_cnt != 255) exp_cnt++;
            end
         end
      end
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic present(input logic [1:0] a, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [3:0] eo, input logic ei);
      ALUOp = a; Funct3 = f3; Funct7 = f7;
      cur_op = eo; cur_ill = ei;
      in_valid = 1'b1;
   endtask

   // Presents an op and holds it until accepted, bounded so the run cannot hang
   task automatic send(input logic [1:0] a, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [3:0] eo, input logic ei);
      bit done = 0;
      present(a, f3, f7, eo, ei);
      for (int k = 0; k < 64 && !done; k++) begin
         @(negedge clk);
         done = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: op %0h never accepted", eo);
      end
   endtask

   task automatic check_reset_outputs();
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_operation", 32'(Operation), 32'd0);
      chk("rst_illegal", 32'(Illegal), 32'd0);
      chk("rst_count", 32'(IllegalCount), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0]  = '{2'b00, 3'b101, 7'h7f, 4'b0010, 1'b0};
      vecs[1]  = '{2'b01, 3'b000, 7'h00, 4'b1000, 1'b0};
      vecs[2]  = '{2'b01, 3'b001, 7'h00, 4'b0011, 1'b0};
      vecs[3]  = '{2'b10, 3'b000, 7'h00, 4'b0010, 1'b0};
      vecs[4]  = '{2'b10, 3'b000, 7'h20, 4'b0011, 1'b0};
      vecs[5]  = '{2'b10, 3'b111, 7'h00, 4'b0000, 1'b0};
      vecs[6]  = '{2'b10, 3'b110, 7'h00, 4'b0001, 1'b0};
      vecs[7]  = '{2'b10, 3'b100, 7'h00, 4'b0100, 1'b0};
      vecs[8]  = '{2'b10, 3'b001, 7'h00, 4'b0110, 1'b0};
      vecs[9]  = '{2'b10, 3'b111, 7'h20, 4'b1111, 1'b1};
      vecs[10] = '{2'b10, 3'b010, 7'h00, 4'b1111, 1'b1};
      vecs[11] = '{2'b10, 3'b001, 7'h20, 4'b1111, 1'b1};
      vecs[12] = '{2'b11, 3'b000, 7'h20, 4'b0010, 1'b0};
      vecs[13] = '{2'b11, 3'b111, 7'h01, 4'b0000, 1'b0};
      vecs[14] = '{2'b11, 3'b110, 7'h00, 4'b0001, 1'b0};
      vecs[15] = '{2'b11, 3'b100, 7'h05, 4'b0100, 1'b0};
      vecs[16] = '{2'b11, 3'b001, 7'h00, 4'b0110, 1'b0};
      vecs[17] = '{2'b11, 3'b001, 7'h01, 4'b1111, 1'b1};
      vecs[18] = '{2'b10, 3'b000, 7'h01, 4'b1111, 1'b1};

      reset = 1'b0;
      step(3);
      reset = 1'b1;
      check_reset_outputs();

      // Decode table, back-to-back with the consumer always ready
      out_ready = 1'b1;
      foreach (vecs[i]) send(vecs[i].aluop, vecs[i].f3, vecs[i].f7, vecs[i].op, vecs[i].ill);
      step(3);

      // Backpressure: ADD to main, XOR to skid, AND stalled until release
      out_ready = 1'b0;
      send(2'b10, 3'b000, 7'h00, 4'b0010, 1'b0);
      send(2'b10, 3'b100, 7'h00, 4'b0100, 1'b0);
      present(2'b10, 3'b111, 7'h00, 4'b0000, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         chk("stall_hold_op", 32'(Operation), 32'b0010);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      send(2'b10, 3'b111, 7'h00, 4'b0000, 1'b0);
      step(4);

      // Illegal counter from zero up to saturation
      reset = 1'b0;
      step(1);
      reset = 1'b1;
      step(1);
      send(2'b10, 3'b010, 7'h00, 4'b1111, 1'b1);
      @(negedge clk);
      chk("count_first", 32'(IllegalCount), 32'd1);
      @(posedge clk);
      #1;
      for (int i = 0; i < 299; i++) send(2'b10, 3'b010, 7'h00, 4'b1111, 1'b1);
      step(2);
      @(negedge clk);
      chk("count_saturated", 32'(IllegalCount), 32'd255);
      @(posedge clk);
      #1;

      // Flush with the skid full and an illegal op presented in the same cycle
      reset = 1'b0;
      step(1);
      reset = 1'b1;
      step(1);
      out_ready = 1'b0;
      send(2'b01, 3'b000, 7'h00, 4'b1000, 1'b0);
      send(2'b10, 3'b110, 7'h00, 4'b0001, 1'b0);
      present(2'b11, 3'b010, 7'h00, 4'b1111, 1'b1);
      flush = 1'b1;
      step(1);
      flush = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      chk("flush_in_ready", 32'(in_ready), 32'd1);
      chk("flush_count", 32'(IllegalCount), 32'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(2'b10, 3'b001, 7'h00, 4'b0110, 1'b0);
      step(3);

      // Mid-stream reset with the skid full, then a normal issue
      out_ready = 1'b0;
      send(2'b10, 3'b010, 7'h00, 4'b1111, 1'b1);
      send(2'b00, 3'b000, 7'h00, 4'b0010, 1'b0);
      reset = 1'b0;
      step(1);
      reset = 1'b1;
      check_reset_outputs();
      out_ready = 1'b1;
      send(2'b10, 3'b000, 7'h20, 4'b0011, 1'b0);
      step(3);

      chk("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
